// File: rtl/s2p_frame_buffer.sv
// s2p_frame_buffer
//   Serial-to-parallel converter for the FFT front end. Collects P_SIZE
//   complex I/Q samples into a fill buffer and hands each complete frame
//   to an output holding register with valid/ready backpressure.
//   Frames can be emitted in natural or bit-reversed slot order.
//
// Parameters
//   DATA_W     width of each signed I and Q sample
//   P_SIZE     samples per frame (power of two, >= 2)
//   BITREV     0: out[k] = k-th sample, 1: out[k] = sample bitrev(k)
//   SOF_ALIGN  1: frames open only on in_sof, 0: in_sof ignored, free-running
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   in_valid, in_sof     sample strobe and start-of-frame marker
//   in_i, in_q           input sample
//   out_valid, out_ready frame handshake
//   out_i, out_q         parallel frame, [P_SIZE-1:0] unpacked
//   overflow             1-cycle pulse: completed frame dropped
//   sof_err              1-cycle pulse: partial frame discarded on mid-frame sof
module s2p_frame_buffer #(
    parameter int DATA_W    = 9,
    parameter int P_SIZE    = 16,
    parameter int BITREV    = 0,
    parameter int SOF_ALIGN = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic signed [DATA_W-1:0] in_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_i [P_SIZE-1:0],
    output logic signed [DATA_W-1:0] out_q [P_SIZE-1:0],
    output logic                     overflow,
    output logic                     sof_err
);

    localparam int CNT_W = $clog2(P_SIZE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(P_SIZE - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic signed [DATA_W-1:0] buf_i [P_SIZE-1:0];
    logic signed [DATA_W-1:0] buf_q [P_SIZE-1:0];

    logic                     accept;
    logic                     restart;
    logic                     sof_mid;
    logic                     complete;
    logic                     load;
    logic [CNT_W-1:0]         wr_cnt;
    logic [CNT_W-1:0]         wr_slot;
    logic signed [DATA_W-1:0] nxt_i [P_SIZE-1:0];
    logic signed [DATA_W-1:0] nxt_q [P_SIZE-1:0];

    function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < CNT_W; b++) begin
            r[b] = v[CNT_W-1-b];
        end
        return r;
    endfunction

    always_comb begin
        accept  = 1'b0;
        restart = 1'b0;
        if (in_valid) begin
            if (state == IDLE) begin
                accept  = in_sof;
                restart = in_sof;
            end else begin
                accept  = 1'b1;
                restart = (SOF_ALIGN != 0) && in_sof;
            end
        end
        sof_mid  = restart && (state == FILL) && (cnt != '0);
        // A frame start always writes slot 0, whatever the running count was.
        wr_cnt   = restart ? '0 : cnt;
        wr_slot  = (BITREV != 0) ? bitrev(wr_cnt) : wr_cnt;
        complete = accept && (wr_cnt == LAST);
        load     = complete && (!out_valid || out_ready);

        // Buffer including the sample accepted this cycle, so the final
        // sample of a frame reaches the output register on the same edge.
        nxt_i = buf_i;
        nxt_q = buf_q;
        if (accept) begin
            nxt_i[wr_slot] = in_i;
            nxt_q[wr_slot] = in_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= (SOF_ALIGN != 0) ? IDLE : FILL;
            cnt       <= '0;
            buf_i     <= '{default: '0};
            buf_q     <= '{default: '0};
            out_i     <= '{default: '0};
            out_q     <= '{default: '0};
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            overflow <= complete && !load;
            sof_err  <= sof_mid;

            if (accept) begin
                buf_i <= nxt_i;
                buf_q <= nxt_q;
                // LAST + 1 wraps to 0 because P_SIZE is a power of two.
                cnt   <= wr_cnt + 1'b1;
                if (complete) begin
                    state <= (SOF_ALIGN != 0) ? IDLE : FILL;
                end else begin
                    state <= FILL;
                end
            end

            if (load) begin
                out_i     <= nxt_i;
                out_q     <= nxt_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_frame_buffer.sv
// Testbench for s2p_frame_buffer: one natural-order and one bit-reversed
// instance share the stimulus; each has its own expected-frame queue which
// a negedge monitor pops on every output handshake.
module tb_s2p_frame_buffer;

    localparam int W = 9;
    localparam int P = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic out_ready = 1'b0;
    logic signed [W-1:0] in_i = '0;
    logic signed [W-1:0] in_q = '0;

    logic n_valid, n_ovf, n_serr;
    logic b_valid, b_ovf, b_serr;
    logic signed [W-1:0] n_oi [P-1:0];
    logic signed [W-1:0] n_oq [P-1:0];
    logic signed [W-1:0] b_oi [P-1:0];
    logic signed [W-1:0] b_oq [P-1:0];

    always #5 clk = ~clk;

    s2p_frame_buffer #(.DATA_W(W), .P_SIZE(P), .BITREV(0), .SOF_ALIGN(1)) dut_nat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof),
        .in_i(in_i), .in_q(in_q), .out_valid(n_valid), .out_ready(out_ready),
        .out_i(n_oi), .out_q(n_oq), .overflow(n_ovf), .sof_err(n_serr)
    );

    s2p_frame_buffer #(.DATA_W(W), .P_SIZE(P), .BITREV(1), .SOF_ALIGN(1)) dut_br (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof),
        .in_i(in_i), .in_q(in_q), .out_valid(b_valid), .out_ready(out_ready),
        .out_i(b_oi), .out_q(b_oq), .overflow(b_ovf), .sof_err(b_serr)
    );

    typedef struct {
        int i [P];
        int q [P];
    } frame_t;

    frame_t qn [$];
    frame_t qb [$];

    int compared = 0;
    int mismatched = 0;
    int n_ovf_cnt = 0;
    int b_ovf_cnt = 0;
    int n_serr_cnt = 0;
    int b_serr_cnt = 0;

    function automatic int brev4(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((v >> b) & 1) != 0) r = r | (1 << (3 - b));
        end
        return r;
    endfunction

    // Expected frame for a ramp base, base+1, ... with q = -i.
    task automatic push_exp(input int base);
        frame_t fn;
        frame_t fb;
        for (int k = 0; k < P; k++) begin
            fn.i[k] = base + k;
            fn.q[k] = -(base + k);
            fb.i[k] = base + brev4(k);
            fb.q[k] = -(base + brev4(k));
        end
        qn.push_back(fn);
        qb.push_back(fb);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_frame(input string nm, input frame_t e,
                             input logic signed [W-1:0] ai [P-1:0],
                             input logic signed [W-1:0] aq [P-1:0]);
        int bad;
        bad = -1;
        compared++;
        for (int k = P - 1; k >= 0; k--) begin
            if (int'(ai[k]) != e.i[k] || int'(aq[k]) != e.q[k]) bad = k;
        end
        if (bad >= 0) begin
            mismatched++;
            $display("FAIL %s: slot %0d got i=%0d q=%0d, required i=%0d q=%0d",
                     nm, bad, ai[bad], aq[bad], e.i[bad], e.q[bad]);
        end
    endtask

    // Monitor: pulse counters and frame scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (n_ovf) n_ovf_cnt++;
        if (b_ovf) b_ovf_cnt++;
        if (n_serr) n_serr_cnt++;
        if (b_serr) b_serr_cnt++;
        if (rstn && n_valid && out_ready) begin
            if (qn.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL nat_frame: unexpected frame out_i[0]=%0d, required no frame", n_oi[0]);
            end else begin
                cmp_frame("nat_frame", qn.pop_front(), n_oi, n_oq);
            end
        end
        if (rstn && b_valid && out_ready) begin
            if (qb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL br_frame: unexpected frame out_i[0]=%0d, required no frame", b_oi[0]);
            end else begin
                cmp_frame("br_frame", qb.pop_front(), b_oi, b_oq);
            end
        end
    end

    task automatic cyc(input logic v, input logic s, input int iv, input int qv);
        in_valid = v;
        in_sof   = s;
        in_i     = W'(iv);
        in_q     = W'(qv);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, 1'b0, 0, 0);
    endtask

    task automatic send_frame(input int base, input bit gaps, input bit ready_last);
        for (int n = 0; n < P; n++) begin
            if (n == P - 1 && ready_last) out_ready = 1'b1;
            cyc(1'b1, n == 0, base + n, -(base + n));
            if (gaps && n != P - 1) cyc(1'b0, 1'b0, 0, 0);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    function automatic int nonzero_outs();
        int nz;
        nz = 0;
        for (int k = 0; k < P; k++) begin
            if (n_oi[k] != 0 || n_oq[k] != 0 || b_oi[k] != 0 || b_oq[k] != 0) nz++;
        end
        return nz;
    endfunction

    initial begin
        // Reset state
        #12;
        chk("rst_valid", n_valid, 0);
        chk("rst_valid_br", b_valid, 0);
        chk("rst_outputs_zero", nonzero_outs(), 0);
        chk("rst_pulses", int'(n_ovf) + int'(n_serr), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Natural / bit-reversed ramp, contiguous, ready high
        out_ready = 1'b1;
        push_exp(0);
        send_frame(0, 1'b0, 1'b0);
        chk("t1_latency", n_valid, 1);
        chk("t1_latency_br", b_valid, 1);
        chk("t2_br_slot1", b_oi[1], 8);
        chk("t2_br_slot3", b_oi[3], 12);
        chk("t2_br_slot15", b_oi[15], 15);
        idle(3);
        chk("t1_valid_drop", n_valid, 0);

        // Gapped input
        push_exp(16);
        send_frame(16, 1'b1, 1'b0);
        chk("t3_latency", n_valid, 1);
        idle(3);

        // Backpressure: second frame dropped
        out_ready = 1'b0;
        push_exp(32);
        send_frame(32, 1'b0, 1'b0);
        chk("t4_valid", n_valid, 1);
        send_frame(64, 1'b0, 1'b0);
        chk("t4_ovf_pulse", n_ovf, 1);
        idle(1);
        chk("t4_ovf_len", n_ovf, 0);
        chk("t4_held_i5", n_oi[5], 37);
        chk("t4_held_q5", n_oq[5], -37);
        chk("t4_ovf_cnt", n_ovf_cnt, 1);
        chk("t4_ovf_cnt_br", b_ovf_cnt, 1);
        out_ready = 1'b1;
        idle(2);
        chk("t4_valid_drop", n_valid, 0);

        // Backpressure released on the completion cycle: no bubble, no overflow
        out_ready = 1'b0;
        push_exp(96);
        send_frame(96, 1'b0, 1'b0);
        push_exp(128);
        send_frame(128, 1'b0, 1'b1);
        chk("t4b_valid", n_valid, 1);
        chk("t4b_no_ovf", n_ovf, 0);
        chk("t4b_new_i0", n_oi[0], 128);
        idle(2);
        chk("t4b_ovf_cnt", n_ovf_cnt, 1);

        // Mid-frame sof
        for (int n = 0; n < 5; n++) cyc(1'b1, n == 0, 10 + n, -(10 + n));
        push_exp(50);
        send_frame(50, 1'b0, 1'b0);
        chk("t5_valid", n_valid, 1);
        idle(2);
        chk("t5_sof_err_cnt", n_serr_cnt, 1);
        chk("t5_sof_err_cnt_br", b_serr_cnt, 1);

        // Reset with a held frame and a partial frame in flight
        out_ready = 1'b0;
        send_frame(80, 1'b0, 1'b0);
        for (int n = 0; n < 7; n++) cyc(1'b1, n == 0, 100 + n, -(100 + n));
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        rstn = 1'b0;
        #2;
        chk("t6_rst_valid", n_valid, 0);
        chk("t6_rst_valid_br", b_valid, 0);
        chk("t6_rst_outputs", nonzero_outs(), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) cyc(1'b1, 1'b0, 90 + n, -(90 + n));
        idle(1);
        chk("t6_ignored", n_valid, 0);
        push_exp(110);
        send_frame(110, 1'b0, 1'b0);
        chk("t6_valid", n_valid, 1);
        idle(3);
        chk("t6_sof_err_cnt", n_serr_cnt, 1);

        for (int t = 0; t < 50 && (qn.size() + qb.size()) != 0; t++) @(posedge clk);
        chk("queues_drained", qn.size() + qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
